// File: rtl/pad_pkg.sv
// Shared definitions for the pad input filter: debounce FSM state encodings
// and interrupt-mode codes, plus small decode helpers for the mode field.
package pad_pkg;

    localparam int unsigned STATE_W    = 2;
    localparam int unsigned IRQ_MODE_W = 2;

    // Debounce FSM: two stable levels, each with a check state for the opposite level.
    typedef enum logic [STATE_W-1:0] {
        STABLE0 = 2'b00,
        CHECK1  = 2'b01,
        STABLE1 = 2'b10,
        CHECK0  = 2'b11
    } pad_state_e;

    // Interrupt source select codes.
    localparam logic [IRQ_MODE_W-1:0] IRQ_NONE = 2'b00;
    localparam logic [IRQ_MODE_W-1:0] IRQ_RISE = 2'b01;
    localparam logic [IRQ_MODE_W-1:0] IRQ_FALL = 2'b10;
    localparam logic [IRQ_MODE_W-1:0] IRQ_BOTH = 2'b11;

    // True when the mode lets an accepted rising change raise the interrupt.
    function automatic logic irq_on_rise(input logic [IRQ_MODE_W-1:0] mode);
        return (mode == IRQ_RISE) || (mode == IRQ_BOTH);
    endfunction

    // True when the mode lets an accepted falling change raise the interrupt.
    function automatic logic irq_on_fall(input logic [IRQ_MODE_W-1:0] mode);
        return (mode == IRQ_FALL) || (mode == IRQ_BOTH);
    endfunction

endpackage : pad_pkg

// File: rtl/pad_sync.sv
// Multi-flop synchronizer for an asynchronous single-bit input.
// Ports:
//   CLK  - clock
//   RST  - synchronous active-high reset, clears every stage
//   D    - asynchronous input
//   Q    - synchronized output (last stage)
module pad_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic D,
    output logic Q
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    // Shift the pad value in at bit 0; bit SYNC_STAGES-1 is the settled output.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], D};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign Q = sync_q[SYNC_STAGES-1];

endmodule : pad_sync

// File: rtl/pad_in_filter.sv
// Pad input filter: synchronizes the pad receive value, debounces it with a
// programmable stability length, reports accepted edges and a sticky IRQ.
// Ports:
//   CLK       - clock
//   RST       - synchronous active-high reset
//   PAD_DOUT  - asynchronous receive value from the pad cell
//   EN        - filter enable; when low the level is frozen
//   DB_LEN    - extra stable cycles required before accepting a change
//   IRQ_MODE  - interrupt source: none / rise / fall / both
//   IRQ_CLR   - clear the sticky interrupt
//   LEVEL     - debounced level (registered)
//   RISE      - one-cycle pulse on accepted 0->1 (registered)
//   FALL      - one-cycle pulse on accepted 1->0 (registered)
//   IRQ       - sticky interrupt flag (registered)
module pad_in_filter
    import pad_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             PAD_DOUT,
    input  logic             EN,
    input  logic [CNT_W-1:0] DB_LEN,
    input  logic [1:0]       IRQ_MODE,
    input  logic             IRQ_CLR,
    output logic             LEVEL,
    output logic             RISE,
    output logic             FALL,
    output logic             IRQ
);

    logic s_sync;

    pad_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             level_q, level_d;
    logic             rise_q,  rise_d;
    logic             fall_q,  fall_d;
    logic             irq_q,   irq_d;

    pad_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .CLK (CLK),
        .RST (RST),
        .D   (PAD_DOUT),
        .Q   (s_sync)
    );

    // Next-state, counter and output decode for the debounce FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;

        if (!EN) begin
            // Park in the stable state that agrees with the held level.
            state_d = level_q ? STABLE1 : STABLE0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                STABLE0: begin
                    if (s_sync) begin
                        state_d = CHECK1;
                        cnt_d   = '0;
                    end
                end
                CHECK1: begin
                    if (!s_sync) begin
                        state_d = STABLE0;
                        cnt_d   = '0;
                    end else if (cnt_q >= DB_LEN) begin
                        // DB_LEN is compared live so a shortened length takes effect at once.
                        state_d = STABLE1;
                        cnt_d   = '0;
                        level_d = 1'b1;
                        rise_d  = 1'b1;
                    end else begin
                        cnt_d = CNT_W'(cnt_q + CNT_W'(1));
                    end
                end
                STABLE1: begin
                    if (!s_sync) begin
                        state_d = CHECK0;
                        cnt_d   = '0;
                    end
                end
                CHECK0: begin
                    if (s_sync) begin
                        state_d = STABLE1;
                        cnt_d   = '0;
                    end else if (cnt_q >= DB_LEN) begin
                        state_d = STABLE0;
                        cnt_d   = '0;
                        level_d = 1'b0;
                        fall_d  = 1'b1;
                    end else begin
                        cnt_d = CNT_W'(cnt_q + CNT_W'(1));
                    end
                end
                default: begin
                    state_d = STABLE0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Sticky interrupt: a new set on the same edge as a clear wins.
    always_comb begin
        irq_d = irq_q;
        if (IRQ_CLR) begin
            irq_d = 1'b0;
        end
        if ((rise_d && irq_on_rise(IRQ_MODE)) || (fall_d && irq_on_fall(IRQ_MODE))) begin
            irq_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= STABLE0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            irq_q   <= irq_d;
        end
    end

    assign LEVEL = level_q;
    assign RISE  = rise_q;
    assign FALL  = fall_q;
    assign IRQ   = irq_q;

endmodule : pad_in_filter

// File: tb/tb_pad_in_filter.sv
// Directed bench for pad_in_filter with default parameters (2 sync stages, 8-bit counter).
module tb_pad_in_filter;

    logic       clk;
    logic       rst;
    logic       pad_dout;
    logic       en;
    logic [7:0] db_len;
    logic [1:0] irq_mode;
    logic       irq_clr;
    logic       level;
    logic       rise;
    logic       fall;
    logic       irq;

    int n_assert;
    int n_fail;

    pad_in_filter #(
        .SYNC_STAGES (2),
        .CNT_W       (8)
    ) dut (
        .CLK      (clk),
        .RST      (rst),
        .PAD_DOUT (pad_dout),
        .EN       (en),
        .DB_LEN   (db_len),
        .IRQ_MODE (irq_mode),
        .IRQ_CLR  (irq_clr),
        .LEVEL    (level),
        .RISE     (rise),
        .FALL     (fall),
        .IRQ      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int e,
                           input logic e_lvl, input logic e_rise,
                           input logic e_fall, input logic e_irq);
        chk($sformatf("%s.level@%0d", tag, e), level, e_lvl);
        chk($sformatf("%s.rise@%0d",  tag, e), rise,  e_rise);
        chk($sformatf("%s.fall@%0d",  tag, e), fall,  e_fall);
        chk($sformatf("%s.irq@%0d",   tag, e), irq,   e_irq);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst      = 1'b1;
        pad_dout = 1'b0;
        en       = 1'b1;
        db_len   = 8'd3;
        irq_mode = 2'b01;
        irq_clr  = 1'b0;

        // Reset for three cycles: every output low.
        for (int e = 1; e <= 3; e++) step();
        chk_all("reset", 3, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // Clean rise, DB_LEN=3: accepted at edge 2+2+3=7, IRQ in rise mode.
        pad_dout = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step();
            chk_all("rise", e, e >= 7, e == 7, 1'b0, e >= 7);
        end

        // Lone clear drops IRQ on the next edge.
        irq_clr = 1'b1;
        step();
        chk_all("clr", 1, 1'b1, 1'b0, 1'b0, 1'b0);
        irq_clr = 1'b0;

        // Fall in fall mode with IRQ_CLR on the FALL edge: set wins, then a clear.
        irq_mode = 2'b10;
        pad_dout = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            step();
            chk_all("fall", e, e < 7, 1'b0, e == 7, e == 7);
            if (e == 6) irq_clr = 1'b1;
        end
        step();
        chk_all("fall_clr", 8, 1'b0, 1'b0, 1'b0, 1'b0);
        irq_clr = 1'b0;

        // High for three cycles only: rejected as a glitch.
        irq_mode = 2'b11;
        pad_dout = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            step();
            chk_all("glitch", e, 1'b0, 1'b0, 1'b0, 1'b0);
            if (e == 3) pad_dout = 1'b0;
        end

        // Reset in the middle of CHECK1 aborts; pad still high is re-debounced in full.
        pad_dout = 1'b1;
        for (int e = 1; e <= 4; e++) step();
        rst = 1'b1;
        step();
        chk_all("midrst", 0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            step();
            chk_all("rerise", e, e >= 7, e == 7, 1'b0, e >= 7);
        end

        // Reset while high with IRQ set clears level and IRQ, then re-accepts.
        rst = 1'b1;
        step();
        chk_all("hirst", 0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            step();
            chk_all("rerise2", e, e >= 7, e == 7, 1'b0, e >= 7);
        end

        // DB_LEN=0: change needs two consecutive stable samples -> edge 4.
        db_len   = 8'd0;
        pad_dout = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            step();
            chk_all("db0fall", e, e < 4, 1'b0, e == 4, 1'b1);
        end

        // DB_LEN=0: a single-sample high is still rejected.
        pad_dout = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            step();
            chk_all("db0glitch", e, 1'b0, 1'b0, 1'b0, 1'b1);
            if (e == 1) pad_dout = 1'b0;
        end

        // Live DB_LEN: shrink from 10 to 2 while CNT=3, accept on the next edge.
        db_len   = 8'd10;
        pad_dout = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step();
            chk_all("live", e, e >= 7, e == 7, 1'b0, 1'b1);
            if (e == 6) db_len = 8'd2;
        end

        // Disabled: pad toggling every 2 cycles leaves everything frozen.
        irq_clr = 1'b1;
        step();
        irq_clr = 1'b0;
        chk("dis_pre.irq", irq, 1'b0);
        en     = 1'b0;
        db_len = 8'd0;
        for (int e = 1; e <= 40; e++) begin
            if (((e - 1) % 4) < 2) pad_dout = 1'b0;
            else                   pad_dout = 1'b1;
            step();
            chk_all("dis", e, 1'b1, 1'b0, 1'b0, 1'b0);
        end

        // Re-enable with pad low: normal filtering resumes from the held level.
        pad_dout = 1'b0;
        en       = 1'b1;
        for (int e = 1; e <= 5; e++) step();
        chk_all("reen", 5, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_pad_in_filter

// File: doc/pad_in_filter.md
PAD_IN_FILTER -- requirements
Module: pad_in_filter

Interface
REQ-001 Parameter SYNC_STAGES, default 2, shall set the synchronizer flop count (legal range 2..4).
REQ-002 Parameter CNT_W, default 8, shall set the debounce counter and DB_LEN width.
REQ-003 CLK  in  1  shall be the single clock; all state updates on its rising edge.
REQ-004 RST  in  1  shall be a synchronous, active-high reset.
REQ-005 PAD_DOUT  in  1  shall be the asynchronous receive value taken from the pad cell DOUT.
REQ-006 EN  in  1  shall enable filtering when high.
REQ-007 DB_LEN  in  CNT_W  shall give the number of extra stable cycles required before a level change is accepted.
REQ-008 IRQ_MODE  in  2  shall select the interrupt source: 00 none, 01 rise, 10 fall, 11 both.
REQ-009 IRQ_CLR  in  1  shall clear IRQ when high.
REQ-010 LEVEL  out  1  shall be the debounced pad level.
REQ-011 RISE  out  1  shall be a one-cycle pulse on an accepted 0->1 change.
REQ-012 FALL  out  1  shall be a one-cycle pulse on an accepted 1->0 change.
REQ-013 IRQ  out  1  shall be a sticky interrupt flag.

Function
REQ-014 PAD_DOUT shall pass through a SYNC_STAGES flop chain; the last stage output is S.
REQ-015 FSM states shall be STABLE0, CHECK1, STABLE1 and CHECK0, with an up-counter CNT of width CNT_W.
REQ-016 In STABLE0, S=1 shall move the FSM to CHECK1 with CNT=0; otherwise the FSM stays in STABLE0.
REQ-017 In CHECK1, S=0 shall return the FSM to STABLE0 with CNT=0 (glitch rejected).
REQ-018 In CHECK1, S=1 with CNT>=DB_LEN shall move the FSM to STABLE1, set LEVEL=1 and pulse RISE on the same edge.
REQ-019 In CHECK1, S=1 with CNT<DB_LEN shall increment CNT.
REQ-020 STABLE1 and CHECK0 shall mirror REQ-016 to REQ-019 with S and LEVEL inverted, pulsing FALL.
REQ-021 DB_LEN shall be compared live; a reduction mid-check that makes CNT>=DB_LEN shall complete the check on the next edge with S held.
REQ-022 Latency: a clean PAD_DOUT step before edge 1 shall update LEVEL at edge SYNC_STAGES+2+DB_LEN, with no earlier and no later update.
REQ-023 With DB_LEN=0, S shall be required stable on two consecutive edges.
REQ-024 When EN=0, the FSM shall go to the stable state matching LEVEL with CNT=0, LEVEL held, and RISE/FALL low; the synchronizer keeps running.
REQ-025 IRQ shall be set on the edge where RISE pulses and IRQ_MODE[0]=1, or FALL pulses and IRQ_MODE[1]=1.
REQ-026 When IRQ set and IRQ_CLR occur on the same edge, set shall win.
REQ-027 IRQ_CLR alone shall clear IRQ on the next edge; IRQ_MODE=00 shall never set IRQ.
REQ-028 RISE and FALL shall never be high in the same cycle.

Reset
REQ-029 RST=1 shall clear the synchronizer flops and CNT, force the FSM to STABLE0, and drive LEVEL, RISE, FALL and IRQ to 0 on the next edge.
REQ-030 Reset mid-check shall abort the check; a pad still high after reset shall be re-debounced in full and produce a RISE pulse.

Structure
REQ-031 The FSM state encodings and IRQ_MODE codes shall live in shared package pad_pkg.
REQ-032 The synchronizer chain shall be sub-module pad_sync (parameter SYNC_STAGES, ports CLK, RST, D, Q).
REQ-033 All outputs shall be driven directly from flops.

Verification
REQ-034 RST=1 for 3 cycles, PAD_DOUT=0, DB_LEN=3 -> LEVEL, RISE, FALL and IRQ are all 0.
REQ-035 DB_LEN=3, IRQ_MODE=01, PAD_DOUT 0->1 before edge 1 -> LEVEL=1 and RISE=1 at edge 7, RISE=0 at edge 8, IRQ=1 from edge 7.
REQ-036 DB_LEN=3, PAD_DOUT high for 3 cycles then low -> LEVEL stays 0, RISE never pulses.
REQ-037 LEVEL=1, IRQ_MODE=10, PAD_DOUT 1->0 with IRQ_CLR=1 on the FALL edge -> IRQ=1; IRQ_CLR=1 one cycle later -> IRQ=0 on the next edge.
REQ-038 RST pulsed during CHECK1 with PAD_DOUT held high -> outputs 0, then LEVEL=1 at SYNC_STAGES+2+DB_LEN edges after RST deasserts, with one RISE pulse.
REQ-039 EN=0 with PAD_DOUT toggling every 2 cycles for 40 cycles -> LEVEL unchanged, no RISE, FALL or IRQ.
